// File: rtl/biquad_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | biquad_seq_if : start/control bundle between biquad sequencer and datapath |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface biquad_seq_if;
  logic       start;
  logic       clr_ovr;
  logic [2:0] controlS;
  logic [1:0] controlC;
  logic [2:0] controlZ;
  logic       en_acum1;
  logic       en_acum2;
  logic       en_acum3;
  logic       en_fk;
  logic       en_yk;
  logic       en_shift;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    input  start, clr_ovr,
    output controlS, controlC, controlZ,
    output en_acum1, en_acum2, en_acum3, en_fk, en_yk, en_shift,
    output busy, done, overrun
  );

  modport slave (
    output start, clr_ovr,
    input  controlS, controlC, controlZ,
    input  en_acum1, en_acum2, en_acum3, en_fk, en_yk, en_shift,
    input  busy, done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/biquad_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | biquad_seq : operand-mux and enable sequencer for a DF-II biquad datapath  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module biquad_seq #(
  parameter int MUL_LAT = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  biquad_seq_if.master bus
);

  localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

  // MAC states are consecutive codes so the sequence advances by increment
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_A1    = 3'd1;
  localparam logic [2:0] ST_A2    = 3'd2;
  localparam logic [2:0] ST_B0    = 3'd3;
  localparam logic [2:0] ST_B1    = 3'd4;
  localparam logic [2:0] ST_B2    = 3'd5;
  localparam logic [2:0] ST_SHIFT = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             mac_last;

  assign mac_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_A1;
      ST_A1, ST_A2, ST_B0, ST_B1, ST_B2: begin
        if (mac_last) state_d = state_q + 3'd1;
        else          cnt_d   = cnt_q + 1'b1;
      end
      ST_SHIFT: state_d = ST_DONE;
      ST_DONE:  state_d = bus.start ? ST_A1 : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // a start accepted in DONE is a legal back-to-back request, not an overrun
    overrun_d = (bus.start && (state_q != ST_IDLE) && (state_q != ST_DONE))
                || (overrun_q && !bus.clr_ovr);
  end

  always_comb begin
    bus.controlS = 3'b000;
    bus.controlC = 2'b00;
    bus.controlZ = 3'b000;
    bus.en_acum1 = 1'b0;
    bus.en_acum2 = 1'b0;
    bus.en_acum3 = 1'b0;
    bus.en_fk    = 1'b0;
    bus.en_yk    = 1'b0;
    bus.en_shift = 1'b0;
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = (state_q == ST_DONE);
    bus.overrun  = overrun_q;
    case (state_q)
      ST_A1: begin
        bus.controlS = 3'b001; bus.controlC = 2'b01; bus.controlZ = 3'b001;
        bus.en_acum1 = mac_last;
      end
      ST_A2: begin
        bus.controlS = 3'b010; bus.controlC = 2'b10; bus.controlZ = 3'b011;
        bus.en_acum2 = mac_last;
        bus.en_fk    = mac_last;
      end
      ST_B0: begin
        bus.controlS = 3'b011; bus.controlC = 2'b11; bus.controlZ = 3'b000;
        bus.en_acum3 = mac_last;
      end
      ST_B1: begin
        bus.controlS = 3'b100; bus.controlC = 2'b01; bus.controlZ = 3'b101;
        bus.en_acum1 = mac_last;
      end
      ST_B2: begin
        bus.controlS = 3'b101; bus.controlC = 2'b10; bus.controlZ = 3'b011;
        bus.en_yk    = mac_last;
        bus.en_acum2 = mac_last;
      end
      ST_SHIFT: bus.en_shift = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_biquad_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_biquad_seq : directed bench for biquad_seq with a Q14 datapath model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_biquad_seq;

  localparam longint A1 = 32112;
  localparam longint A2 = -15736;
  localparam longint B0 = 16384;
  localparam longint B1 = -32768;
  localparam longint B2 = 16384;
  localparam longint UK = 16384;
  localparam int     NS = 20;

  localparam logic [7:0] EXP_SEL [5] = '{8'b001_01_001, 8'b010_10_011, 8'b011_11_000,
                                         8'b100_01_101, 8'b101_10_011};
  localparam logic [5:0] EXP_EN  [5] = '{6'b100000, 6'b010100, 6'b001000,
                                         6'b100000, 6'b010010};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  biquad_seq_if if0 ();
  biquad_seq_if if2 ();

  biquad_seq #(.MUL_LAT(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.master));
  biquad_seq #(.MUL_LAT(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.master));

  logic [7:0] sel0, sel2;
  logic [5:0] en0, en2;
  assign sel0 = {if0.controlS, if0.controlC, if0.controlZ};
  assign sel2 = {if2.controlS, if2.controlC, if2.controlZ};
  assign en0  = {if0.en_acum1, if0.en_acum2, if0.en_acum3, if0.en_fk, if0.en_yk, if0.en_shift};
  assign en2  = {if2.en_acum1, if2.en_acum2, if2.en_acum3, if2.en_fk, if2.en_yk, if2.en_shift};

  // Datapath driven by dut0; the input is attenuated by 4 for headroom
  longint fk, fk1, fk2, acum1, acum2, acum3, yk;
  longint coef, st, add, mac_res;

  always_comb begin
    coef = 0;
    st   = 0;
    add  = 0;
    case (if0.controlS)
      3'd1: coef = A1;
      3'd2: coef = A2;
      3'd3: coef = B0;
      3'd4: coef = B1;
      3'd5: coef = B2;
      default: coef = 0;
    endcase
    case (if0.controlC)
      2'd1: st = fk1;
      2'd2: st = fk2;
      2'd3: st = fk;
      default: st = 0;
    endcase
    case (if0.controlZ)
      3'd1: add = UK >>> 2;
      3'd2: add = yk;
      3'd3: add = acum1;
      3'd4: add = acum2;
      3'd5: add = acum3;
      default: add = 0;
    endcase
    mac_res = ((coef * st) >>> 14) + add;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      fk <= 0; fk1 <= 0; fk2 <= 0; acum1 <= 0; acum2 <= 0; acum3 <= 0; yk <= 0;
    end else begin
      if (if0.en_acum1) acum1 <= mac_res;
      if (if0.en_acum2) acum2 <= mac_res;
      if (if0.en_acum3) acum3 <= mac_res;
      if (if0.en_fk)    fk    <= mac_res;
      if (if0.en_yk)    yk    <= mac_res;
      if (if0.en_shift) begin
        fk2 <= fk1;
        fk1 <= fk;
      end
    end
  end

  longint gold_y [NS];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_done0(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!if0.done && cycles < 20);
    check_eq("done_seen", if0.done, 1);
  endtask

  initial begin
    longint w, w1, w2;
    w1 = 0;
    w2 = 0;
    for (int n = 0; n < NS; n++) begin
      w = (UK >>> 2) + ((A1 * w1) >>> 14) + ((A2 * w2) >>> 14);
      gold_y[n] = ((B0 * w) >>> 14) + ((B1 * w1) >>> 14) + ((B2 * w2) >>> 14);
      w2 = w1;
      w1 = w;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset_n     = 1'b0;
    if0.start   = 1'b0;
    if0.clr_ovr = 1'b0;
    if2.start   = 1'b0;
    if2.clr_ovr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_sel", sel0, 0);
    check_eq("rst_en", en0, 0);
    check_eq("rst_flags", {if0.busy, if0.done, if0.overrun}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", if0.busy, 0);

    // First sample, cycle by cycle
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("sel_mac%0d", i), sel0, EXP_SEL[i]);
      check_eq($sformatf("en_mac%0d", i), en0, EXP_EN[i]);
      check_eq($sformatf("busy_mac%0d", i), if0.busy, 1);
      @(negedge clk);
    end
    check_eq("shift_sel", sel0, 0);
    check_eq("shift_en", en0, 6'b000001);
    check_eq("shift_done", if0.done, 0);
    @(negedge clk);
    check_eq("done0", if0.done, 1);
    check_eq("done0_busy", if0.busy, 1);
    check_eq("yk0_hand", yk, 64'd4096);
    check_eq("yk0_gold", yk, gold_y[0]);

    // Remaining samples back-to-back: start issued in the DONE cycle
    for (int s = 1; s < NS; s++) begin
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      check_eq($sformatf("b2b_a1_%0d", s), sel0, EXP_SEL[0]);
      wait_done0(cyc);
      if (s == 1) begin
        check_eq("b2b_latency", cyc, 6);
        check_eq("yk1_hand", yk, 64'd3932);
      end
      check_eq($sformatf("yk%0d_gold", s), yk, gold_y[s]);
    end
    check_eq("b2b_no_ovr", if0.overrun, 0);
    @(negedge clk);
    check_eq("idle_after", if0.busy, 0);

    // Start during B0 is ignored and flags overrun
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (2) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    check_eq("ovr_set", if0.overrun, 1);
    check_eq("ovr_norestart", sel0, EXP_SEL[3]);
    wait_done0(cyc);
    check_eq("ovr_sticky", if0.overrun, 1);
    @(negedge clk);
    if0.clr_ovr = 1'b1;
    @(negedge clk);
    if0.clr_ovr = 1'b0;
    check_eq("ovr_clr", if0.overrun, 0);

    // Set wins over clear; then async reset in B1
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    @(negedge clk);
    if0.start   = 1'b1;
    if0.clr_ovr = 1'b1;
    @(negedge clk);
    if0.start   = 1'b0;
    if0.clr_ovr = 1'b0;
    check_eq("ovr_set_wins", if0.overrun, 1);
    @(negedge clk);
    check_eq("pre_rst_b1", sel0, EXP_SEL[3]);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_sel", sel0, 0);
    check_eq("arst_en", en0, 0);
    check_eq("arst_flags", {if0.busy, if0.done, if0.overrun}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", if0.busy, 0);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    check_eq("post_rst_a1", sel0, EXP_SEL[0]);
    wait_done0(cyc);
    check_eq("post_rst_lat", cyc, 6);

    // MUL_LAT=2: selects held 3 cycles, enable on the third, done 17 cycles after start
    @(negedge clk);
    if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        check_eq($sformatf("l2_sel%0d_%0d", i, c), sel2, EXP_SEL[i]);
        check_eq($sformatf("l2_en%0d_%0d", i, c), en2, (c == 2) ? EXP_EN[i] : 6'b0);
        @(negedge clk);
      end
    end
    check_eq("l2_shift", en2, 6'b000001);
    check_eq("l2_nodone16", if2.done, 0);
    @(negedge clk);
    check_eq("l2_done17", if2.done, 1);
    @(negedge clk);
    check_eq("l2_idle", if2.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
